div_share_ctrl: RTL



---
 rtl/div_share_ctrl_pkg.sv | 19 +
 rtl/div_share_ctrl_div_core.sv | 131 +++++++++++++
 rtl/div_share_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/div_share_ctrl_pkg.sv
// div_share_ctrl_pkg
// Shared definitions for the dual-lane divider sequencer: FSM state encoding,
// default datapath width and iteration count, lane count and the width of a
// packed {divisor, dividend} lane operand bus.
// Optional feature macro used by the design files: DIV_FAST_PATH_EN.
package div_share_ctrl_pkg;

  localparam int DIV_W_DFLT = 32;
  localparam int ITER_DFLT  = 32;
  localparam int NUM_LANES  = 2;
  localparam int LANE_BUS_W = 2 * DIV_W_DFLT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_share_ctrl_div_core.sv
// div_core
// Iterative radix-2 restoring divider datapath shared by both EX lanes.
// Latches operand magnitudes and result sign flags on start, performs one
// restoring step per cycle while active, and registers the sign-corrected
// quotient/remainder on the final step.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          latch operands of the granted lane (one cycle)
//   abort          drop the operation in flight; results are left untouched
//   sign           1 = signed operands
//   dividend       raw dividend of the granted lane
//   divisor        raw divisor of the granted lane
//   fast           combinational: the start operands can be resolved at once
//   last           combinational: this cycle is the final restoring step
//   quotient       registered result quotient
//   remainder      registered result remainder
// Macro DIV_FAST_PATH_EN: when defined, `fast` flags divide-by-zero and
// |dividend| < |divisor| so the result is written on the start edge.
module div_core
  import div_share_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DFLT,
  parameter int ITER  = ITER_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             sign,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             fast,
  output logic             last,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] quo;
  logic [DIV_W-1:0] dv;
  logic             q_neg;
  logic             r_neg;

  // Start-side magnitudes and sign flags
  logic             dd_neg_in;
  logic             dv_neg_in;
  logic [DIV_W-1:0] dd_abs_in;
  logic [DIV_W-1:0] dv_abs_in;
  logic             q_neg_in;
  logic             r_neg_in;
  logic [DIV_W-1:0] fast_q;
  logic [DIV_W-1:0] fast_r;

  // One restoring step
  logic [DIV_W:0]   rem_sh;
  logic [DIV_W-1:0] diff;
  logic             ge;
  logic [DIV_W-1:0] rem_nx;
  logic [DIV_W-1:0] quo_nx;

  assign dd_neg_in = sign & dividend[DIV_W-1];
  assign dv_neg_in = sign & divisor[DIV_W-1];
  assign dd_abs_in = dd_neg_in ? -dividend : dividend;
  assign dv_abs_in = dv_neg_in ? -divisor  : divisor;
  assign q_neg_in  = sign & (dividend[DIV_W-1] ^ divisor[DIV_W-1]);
  assign r_neg_in  = dd_neg_in;

  // Early result: divide-by-zero gives all-ones, otherwise quotient is zero;
  // the remainder is the dividend magnitude in both cases.
  assign fast_q = (dv_abs_in == '0) ? {DIV_W{1'b1}} : '0;
  assign fast_r = dd_abs_in;

`ifdef DIV_FAST_PATH_EN
  assign fast = (dv_abs_in == '0) || (dd_abs_in < dv_abs_in);
`else
  assign fast = 1'b0;
`endif

  // Shifted partial remainder needs one extra bit; when it is >= dv the
  // difference always fits back into DIV_W bits.
  assign rem_sh = {rem, quo[DIV_W-1]};
  assign ge     = rem_sh >= {1'b0, dv};
  assign diff   = rem_sh[DIV_W-1:0] - dv;
  assign rem_nx = ge ? diff : rem_sh[DIV_W-1:0];
  assign quo_nx = {quo[DIV_W-2:0], ge};

  assign last = active && (cnt == CNT_W'(ITER - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= 1'b0;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dv        <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (abort) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= dd_abs_in;
      dv     <= dv_abs_in;
      q_neg  <= q_neg_in;
      r_neg  <= r_neg_in;
      active <= !fast;
      if (fast) begin
        quotient  <= q_neg_in ? -fast_q : fast_q;
        remainder <= r_neg_in ? -fast_r : fast_r;
      end
    end else if (active) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        active    <= 1'b0;
        quotient  <= q_neg ? -quo_nx : quo_nx;
        remainder <= r_neg ? -rem_nx : rem_nx;
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl
// Arbiter and sequencer sharing one iterative divider between two EX lanes.
// Lane0 (older instruction) has fixed priority. A granted lane owns the
// divider until its instruction fires to MEM, drops its request, or a WB
// exception flush arrives.
// Handshake: div_en_i[l] is a level request held while the div sits in EX;
// div_complete_o[l] is high every cycle the result is valid (DONE state) and
// stays high until lane_fire_i[l] or a request drop releases the divider.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   excep_flush_i            kill any operation, mask completion, block grant
//   div_en_i[1:0]            per-lane request level
//   div_sign_i[1:0]          per-lane signed flag
//   dividend0_i/divisor0_i   lane0 operands
//   dividend1_i/divisor1_i   lane1 operands
//   lane_fire_i[1:0]         lane's EX instruction advances this cycle
//   grant_o[1:0]             one-hot owner, 0 when idle
//   busy_o                   FSM not idle
//   div_complete_o[1:0]      one-hot result valid for the owner lane
//   quotient_o, remainder_o  registered results
// Macro DIV_FAST_PATH_EN: enables the single-cycle path for divide-by-zero and
// |dividend| < |divisor|.
module div_share_ctrl
  import div_share_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DFLT,
  parameter int ITER  = ITER_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 excep_flush_i,
  input  logic [NUM_LANES-1:0] div_en_i,
  input  logic [NUM_LANES-1:0] div_sign_i,
  input  logic [DIV_W-1:0]     dividend0_i,
  input  logic [DIV_W-1:0]     divisor0_i,
  input  logic [DIV_W-1:0]     dividend1_i,
  input  logic [DIV_W-1:0]     divisor1_i,
  input  logic [NUM_LANES-1:0] lane_fire_i,
  output logic [NUM_LANES-1:0] grant_o,
  output logic                 busy_o,
  output logic [NUM_LANES-1:0] div_complete_o,
  output logic [DIV_W-1:0]     quotient_o,
  output logic [DIV_W-1:0]     remainder_o
);

  div_state_e           state;
  div_state_e           state_nx;
  logic [NUM_LANES-1:0] grant_q;
  logic [NUM_LANES-1:0] grant_sel;

  logic                 sel_lane;
  logic                 sel_sign;
  logic [2*DIV_W-1:0]   lane_bus [NUM_LANES];
  logic [2*DIV_W-1:0]   sel_bus;

  logic                 owner;
  logic                 owner_en;
  logic                 owner_fire;

  logic                 core_start;
  logic                 core_abort;
  logic                 core_fast;
  logic                 core_last;

  // Lane operand buses packed as {divisor, dividend}
  assign lane_bus[0] = {divisor0_i, dividend0_i};
  assign lane_bus[1] = {divisor1_i, dividend1_i};

  // Fixed priority: lane0 whenever it requests
  assign sel_lane  = ~div_en_i[0];
  assign grant_sel = div_en_i[0] ? 2'b01 : 2'b10;
  assign sel_bus   = lane_bus[sel_lane];
  assign sel_sign  = div_sign_i[sel_lane];

  assign owner      = grant_q[1];
  assign owner_en   = div_en_i[owner];
  assign owner_fire = lane_fire_i[owner];

  // State register and owner register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant_q <= '0;
    end else begin
      state <= state_nx;
      if (state_nx == ST_IDLE) begin
        grant_q <= '0;
      end else if (state == ST_IDLE) begin
        grant_q <= grant_sel;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (!excep_flush_i && (div_en_i != '0)) begin
          state_nx = core_fast ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (excep_flush_i || !owner_en) begin
          state_nx = ST_IDLE;
        end else if (core_last) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (excep_flush_i || owner_fire || !owner_en) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs and core control
  always_comb begin
    busy_o         = (state != ST_IDLE);
    grant_o        = grant_q;
    // Flush masks completion in the same cycle it is raised
    div_complete_o = ((state == ST_DONE) && !excep_flush_i) ? grant_q : '0;
    core_start     = (state == ST_IDLE) && (state_nx != ST_IDLE);
    // Abort takes priority over a coincident final step in the core
    core_abort     = (state == ST_CALC) && (state_nx == ST_IDLE);
  end

  div_core #(
    .DIV_W (DIV_W),
    .ITER  (ITER)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .abort     (core_abort),
    .sign      (sel_sign),
    .dividend  (sel_bus[DIV_W-1:0]),
    .divisor   (sel_bus[2*DIV_W-1:DIV_W]),
    .fast      (core_fast),
    .last      (core_last),
    .quotient  (quotient_o),
    .remainder (remainder_o)
  );

endmodule
